// File: rtl/i2s_pkg.sv
// Shared I2S definitions: word-select encoding, transmitter state type and
// default sample/slot widths used by both the transmitter and the receiver.
package i2s_pkg;

  localparam int   I2S_DATA_W   = 24;
  localparam int   I2S_SLOT_W   = 32;
  localparam logic I2S_WS_LEFT  = 1'b0;
  localparam logic I2S_WS_RIGHT = 1'b1;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_RUN  = 1'b1
  } tx_state_t;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int i2s_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// Synchronous frame FIFO for the I2S transmitter. Head is presented
// combinationally (first-word fall-through); pushes at full and pops at
// empty are ignored. Level is a register so full/empty are glitch-free.
module i2s_tx_fifo #(
  parameter  int WIDTH = 48,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [LW-1:0]    o_level,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_head  = r_mem[r_rd_ptr];

  // Storage array, no reset needed: contents are qualified by the level.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: divides clk down to SCK, generates WS with the
// standard one-bit delay and shifts stereo frames out MSB-first on SD.
// Optional build macro I2S_TX_TEST_PATTERN_EN adds a test_mode input that
// replaces FIFO frames with an internal ramp (left = ramp, right = ~ramp).
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   TX_IDLE | outputs and counters held at 0, FIFO contents kept
//   TX_RUN  | SCK running, frame loaded on entry and at every frame end
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W     = I2S_DATA_W,
  parameter int SLOT_W     = I2S_SLOT_W,
  parameter int SCK_DIV    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [DATA_W-1:0]             in_left,
  input  logic [DATA_W-1:0]             in_right,
  input  logic                          in_valid,
`ifdef I2S_TX_TEST_PATTERN_EN
  input  logic                          test_mode,
`endif
  output logic                          in_ready,
  output logic                          i2s_sck,
  output logic                          i2s_ws,
  output logic                          i2s_sd,
  output logic                          underrun,
  output logic [15:0]                   underrun_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV_W   = i2s_cnt_w(SCK_DIV);
  localparam int BIT_W   = i2s_cnt_w(2 * SLOT_W);
  localparam int FRAME_W = 2 * DATA_W;

  tx_state_t          r_state;
  tx_state_t          w_state_nxt;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic               r_sck;
  logic               r_ws;
  logic               r_sd;
  logic [FRAME_W-1:0] r_frame;
  logic               r_underrun;
  logic [15:0]        r_underrun_cnt;

  logic               w_tick;
  logic               w_fall;
  logic               w_load;
  logic               w_run;
  logic               w_use_ramp;
  logic               w_starve;
  logic               w_push;
  logic               w_pop;
  logic [FRAME_W-1:0] w_fifo_head;
  logic [FRAME_W-1:0] w_frame_src;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [BIT_W-1:0]   w_bit_inc;
  logic [BIT_W-1:0]   w_j;
  logic [DATA_W-1:0]  w_chan;
  logic [DATA_W-1:0]  w_chan_shift;
  logic               w_sd_nxt;
  logic               w_ws_nxt;

  // in_ready comes straight from the registered level, so a pop at full
  // only reopens the port on the following cycle.
  assign in_ready = !w_fifo_full;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = w_load && !w_use_ramp && !w_fifo_empty;
  assign w_starve = w_load && !w_use_ramp && w_fifo_empty;

  i2s_tx_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  ({in_left, in_right}),
    .i_pop   (w_pop),
    .o_head  (w_fifo_head),
    .o_level (fifo_level),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

`ifdef I2S_TX_TEST_PATTERN_EN
  logic [DATA_W-1:0] r_ramp;

  assign w_use_ramp  = test_mode;
  assign w_frame_src = w_use_ramp ? {r_ramp, ~r_ramp}
                                  : (w_fifo_empty ? '0 : w_fifo_head);

  // Ramp advances once per test-pattern frame load, wrapping naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    r_ramp <= '0;
    else if (w_load && w_use_ramp) r_ramp <= r_ramp + 1'b1;
  end
`else
  assign w_use_ramp  = 1'b0;
  assign w_frame_src = w_fifo_empty ? '0 : w_fifo_head;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= TX_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state plus the divider tick, fall event and frame-load strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_tick      = 1'b0;
    w_fall      = 1'b0;
    w_load      = 1'b0;
    w_run       = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (enable) begin
          w_state_nxt = TX_RUN;
          w_load      = 1'b1;
        end
      end
      TX_RUN: begin
        if (!enable) begin
          w_state_nxt = TX_IDLE;
        end else begin
          w_run  = 1'b1;
          w_tick = (r_div_cnt == DIV_W'(SCK_DIV - 1));
          w_fall = w_tick && r_sck;
          w_load = w_fall && (r_bit_cnt == BIT_W'(2 * SLOT_W - 1));
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  // Bit selection for the current slot position; shifting past DATA_W
  // naturally yields the zero padding at the end of each slot.
  always_comb begin
    w_j    = r_bit_cnt;
    w_chan = r_frame[FRAME_W-1 -: DATA_W];
    if (r_bit_cnt >= BIT_W'(SLOT_W)) begin
      w_j    = r_bit_cnt - BIT_W'(SLOT_W);
      w_chan = r_frame[DATA_W-1:0];
    end
    w_chan_shift = w_chan << w_j;
    w_sd_nxt     = w_chan_shift[DATA_W-1];
    w_bit_inc    = (r_bit_cnt == BIT_W'(2 * SLOT_W - 1)) ? '0 : r_bit_cnt + 1'b1;
    w_ws_nxt     = (w_bit_inc >= BIT_W'(SLOT_W)) ? I2S_WS_RIGHT : I2S_WS_LEFT;
  end

  // SCK divider and serial outputs; anything outside RUN forces them to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_sck     <= 1'b0;
      r_ws      <= 1'b0;
      r_sd      <= 1'b0;
    end else if (!w_run) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_sck     <= 1'b0;
      r_ws      <= 1'b0;
      r_sd      <= 1'b0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      if (w_tick) r_sck <= ~r_sck;
      if (w_fall) begin
        r_sd      <= w_sd_nxt;
        r_ws      <= w_ws_nxt;
        r_bit_cnt <= w_bit_inc;
      end
    end
  end

  // Frame register: next frame is captured while the last bit goes out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_frame <= '0;
    else if (w_load) r_frame <= w_frame_src;
  end

  // Underrun pulse and saturating counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      r_underrun <= w_starve;
      if (w_starve && (r_underrun_cnt != 16'hFFFF))
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign i2s_sck      = r_sck;
  assign i2s_ws       = r_ws;
  assign i2s_sd       = r_sd;
  assign underrun     = r_underrun;
  assign underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx with SCK_DIV=2 (SCK = clk/4). Serial data is
// captured on SCK rising edges; expected frames are hand-built constants.
module tb_i2s_tx;

  localparam int SCK_DIV = 2;
  localparam logic [63:0] EXP_WS = 64'h0000_0001_FFFF_FFFE;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [23:0] in_left = '0;
  logic [23:0] in_right = '0;
  logic        in_valid = 1'b0;
`ifdef I2S_TX_TEST_PATTERN_EN
  logic        test_mode = 1'b0;
`endif
  logic        in_ready;
  logic        i2s_sck;
  logic        i2s_ws;
  logic        i2s_sd;
  logic        underrun;
  logic [15:0] underrun_cnt;
  logic [2:0]  fifo_level;

  int n_tests = 0;
  int n_fail  = 0;
  int n_und   = 0;

  logic cap_sd [0:511];
  logic cap_ws [0:511];

  i2s_tx #(
    .DATA_W(24), .SLOT_W(32), .SCK_DIV(SCK_DIV), .FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .in_left      (in_left),
    .in_right     (in_right),
    .in_valid     (in_valid),
`ifdef I2S_TX_TEST_PATTERN_EN
    .test_mode    (test_mode),
`endif
    .in_ready     (in_ready),
    .i2s_sck      (i2s_sck),
    .i2s_ws       (i2s_ws),
    .i2s_sd       (i2s_sd),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (underrun) n_und++;

  // Record SD/WS at each of the next n SCK rising edges (bounded).
  task automatic capture(input int n, output bit to);
    int   got;
    int   cyc;
    logic prev;
    got = 0; cyc = 0; to = 1'b0; prev = i2s_sck;
    while (got < n && !to) begin
      @(negedge clk);
      cyc++;
      if (!prev && i2s_sck) begin
        cap_sd[got] = i2s_sd;
        cap_ws[got] = i2s_ws;
        got++;
      end
      prev = i2s_sck;
      if (cyc > n * 4 * SCK_DIV + 40) to = 1'b1;
    end
  endtask

  function automatic logic [63:0] frame_bits(input int base, input bit use_ws);
    logic [63:0] v;
    for (int i = 0; i < 64; i++) v[63-i] = use_ws ? cap_ws[base+i] : cap_sd[base+i];
    return v;
  endfunction

  // Present one frame and hold it until accepted (bounded).
  task automatic push(input logic [23:0] l, input logic [23:0] r);
    int cyc;
    in_left = l; in_right = r; in_valid = 1'b1; cyc = 0;
    while (!in_ready && cyc < 2000) begin
      @(posedge clk); #1; cyc++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_tests++; if ({i2s_sck, i2s_ws, i2s_sd, underrun} !== 4'b0) begin n_fail++;
      $display("FAIL reset_outs: got %b required 0000", {i2s_sck, i2s_ws, i2s_sd, underrun}); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_ready: got %b required 1", in_ready); end
    n_tests++; if (fifo_level !== 3'd0 || underrun_cnt !== 16'd0) begin n_fail++;
      $display("FAIL reset_level_cnt: level=%0d cnt=%0d required 0 0", fifo_level, underrun_cnt); end
    #21 reset = 1'b0;
    @(posedge clk); #1;
    n_tests++; if ({i2s_sck, i2s_ws, i2s_sd} !== 3'b0 || in_ready !== 1'b1) begin n_fail++;
      $display("FAIL post_reset: sck/ws/sd=%b ready=%b required 000 1", {i2s_sck, i2s_ws, i2s_sd}, in_ready); end
  endtask

  task automatic test_basic();
    bit to;
    push(24'hA5A5A5, 24'h5A5A5A);
    push(24'h123456, 24'hFEDCBA);
    push(24'h800001, 24'h7FFFFE);
    n_tests++; if (fifo_level !== 3'd3) begin n_fail++;
      $display("FAIL basic_level: got %0d required 3", fifo_level); end
    enable = 1'b1;
    capture(129, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL basic_capture: timeout required 129 rises"); end
    n_tests++; if (cap_sd[0] !== 1'b0 || cap_ws[0] !== 1'b0) begin n_fail++;
      $display("FAIL basic_prebit: sd=%b ws=%b required 0 0", cap_sd[0], cap_ws[0]); end
    n_tests++; if (frame_bits(1, 0) !== {24'hA5A5A5, 8'h00, 24'h5A5A5A, 8'h00}) begin n_fail++;
      $display("FAIL basic_sd_f1: got %h required %h", frame_bits(1, 0), {24'hA5A5A5, 8'h00, 24'h5A5A5A, 8'h00}); end
    n_tests++; if (frame_bits(1, 1) !== EXP_WS) begin n_fail++;
      $display("FAIL basic_ws_f1: got %h required %h", frame_bits(1, 1), EXP_WS); end
    n_tests++; if (frame_bits(65, 0) !== {24'h123456, 8'h00, 24'hFEDCBA, 8'h00}) begin n_fail++;
      $display("FAIL basic_sd_f2: got %h required %h", frame_bits(65, 0), {24'h123456, 8'h00, 24'hFEDCBA, 8'h00}); end
    n_tests++; if (frame_bits(65, 1) !== EXP_WS) begin n_fail++;
      $display("FAIL basic_ws_f2: got %h required %h", frame_bits(65, 1), EXP_WS); end
    n_tests++; if (underrun_cnt !== 16'd0 || fifo_level !== 3'd0) begin n_fail++;
      $display("FAIL basic_after: cnt=%0d level=%0d required 0 0", underrun_cnt, fifo_level); end
    enable = 1'b0;
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_underrun();
    bit   to;
    logic any_sd;
    n_und = 0;
    enable = 1'b1;
    capture(192, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL und_capture: timeout required 192 rises"); end
    any_sd = 1'b0;
    for (int i = 0; i < 192; i++) any_sd = any_sd | cap_sd[i];
    n_tests++; if (any_sd !== 1'b0) begin n_fail++;
      $display("FAIL und_sd_zero: got %b required 0", any_sd); end
    n_tests++; if (underrun_cnt !== 16'd3 || n_und != 3) begin n_fail++;
      $display("FAIL und_count: cnt=%0d pulses=%0d required 3 3", underrun_cnt, n_und); end
    push(24'h0F0F0F, 24'hF0F0F0);
    capture(65, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL und_capture2: timeout required 65 rises"); end
    n_tests++; if (frame_bits(1, 0) !== {24'h0F0F0F, 8'h00, 24'hF0F0F0, 8'h00}) begin n_fail++;
      $display("FAIL und_next_frame: got %h required %h", frame_bits(1, 0), {24'h0F0F0F, 8'h00, 24'hF0F0F0, 8'h00}); end
    n_tests++; if (underrun_cnt !== 16'd4) begin n_fail++;
      $display("FAIL und_count2: got %0d required 4", underrun_cnt); end
    enable = 1'b0;
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bit   to;
    int   idx;
    int   cyc;
    logic acc;
    idx = 0; cyc = 0;
    in_valid = 1'b1;
    while (idx < 4 && cyc < 50) begin
      in_left = 24'h100000 + 24'(idx); in_right = 24'h200000 + 24'(idx);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_left = 24'h100004; in_right = 24'h200004;
    repeat (3) @(posedge clk); #1;
    n_tests++; if (in_ready !== 1'b0 || fifo_level !== 3'd4) begin n_fail++;
      $display("FAIL b2b_full: ready=%b level=%0d required 0 4", in_ready, fifo_level); end
    enable = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (fifo_level !== 3'd3 || in_ready !== 1'b1) begin n_fail++;
      $display("FAIL b2b_pop_at_full: level=%0d ready=%b required 3 1", fifo_level, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++; if (fifo_level !== 3'd4) begin n_fail++;
      $display("FAIL b2b_fifth_accepted: level=%0d required 4", fifo_level); end
    capture(321, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL b2b_capture: timeout required 321 rises"); end
    for (int m = 0; m < 5; m++) begin
      n_tests++;
      if (frame_bits(1 + 64 * m, 0) !== {24'h100000 + 24'(m), 8'h00, 24'h200000 + 24'(m), 8'h00}) begin
        n_fail++;
        $display("FAIL b2b_frame%0d: got %h required %h", m, frame_bits(1 + 64 * m, 0),
                 {24'h100000 + 24'(m), 8'h00, 24'h200000 + 24'(m), 8'h00});
      end
    end
    enable = 1'b0;
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_abort();
    bit          to;
    logic [19:0] part;
    push(24'hABCDFF, 24'h135790);
    push(24'h2468AC, 24'hFEDCBA);
    enable = 1'b1;
    capture(21, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL abort_capture: timeout required 21 rises"); end
    for (int i = 0; i < 20; i++) part[19-i] = cap_sd[1+i];
    n_tests++; if (part !== 20'hABCDF || i2s_sd !== 1'b1 || i2s_sck !== 1'b1) begin n_fail++;
      $display("FAIL abort_partial: bits=%h sd=%b sck=%b required abcdf 1 1", part, i2s_sd, i2s_sck); end
    enable = 1'b0;
    @(posedge clk); #1;
    n_tests++; if ({i2s_sck, i2s_ws, i2s_sd} !== 3'b000 || fifo_level !== 3'd1) begin n_fail++;
      $display("FAIL abort_idle: sck/ws/sd=%b level=%0d required 000 1", {i2s_sck, i2s_ws, i2s_sd}, fifo_level); end
    repeat (3) @(posedge clk); #1;
    enable = 1'b1;
    capture(65, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL abort_capture2: timeout required 65 rises"); end
    n_tests++; if (frame_bits(1, 0) !== {24'h2468AC, 8'h00, 24'hFEDCBA, 8'h00} || frame_bits(1, 1) !== EXP_WS) begin n_fail++;
      $display("FAIL abort_restart: sd=%h ws=%h required %h %h", frame_bits(1, 0), frame_bits(1, 1),
               {24'h2468AC, 8'h00, 24'hFEDCBA, 8'h00}, EXP_WS); end
    enable = 1'b0;
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit to;
    push(24'h000000, 24'hFFFFFF);
    push(24'h111111, 24'h222222);
    enable = 1'b1;
    capture(41, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL rmid_capture: timeout required 41 rises"); end
    n_tests++; if (i2s_ws !== 1'b1 || i2s_sd !== 1'b1 || fifo_level !== 3'd1) begin n_fail++;
      $display("FAIL rmid_pre: ws=%b sd=%b level=%0d required 1 1 1", i2s_ws, i2s_sd, fifo_level); end
    #3 reset = 1'b1;
    #1;
    n_tests++; if ({i2s_sck, i2s_ws, i2s_sd, underrun} !== 4'b0 || in_ready !== 1'b1) begin n_fail++;
      $display("FAIL rmid_outs: sck/ws/sd/und=%b ready=%b required 0000 1", {i2s_sck, i2s_ws, i2s_sd, underrun}, in_ready); end
    n_tests++; if (fifo_level !== 3'd0 || underrun_cnt !== 16'd0) begin n_fail++;
      $display("FAIL rmid_state: level=%0d cnt=%0d required 0 0", fifo_level, underrun_cnt); end
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

`ifdef I2S_TX_TEST_PATTERN_EN
  task automatic test_pattern();
    bit to;
    n_und = 0;
    test_mode = 1'b1;
    push(24'h777777, 24'h888888);
    enable = 1'b1;
    capture(193, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL pat_capture: timeout required 193 rises"); end
    n_tests++; if (frame_bits(1, 0) !== {24'h000000, 8'h00, 24'hFFFFFF, 8'h00}) begin n_fail++;
      $display("FAIL pat_frame0: got %h", frame_bits(1, 0)); end
    n_tests++; if (frame_bits(65, 0) !== {24'h000001, 8'h00, 24'hFFFFFE, 8'h00}) begin n_fail++;
      $display("FAIL pat_frame1: got %h", frame_bits(65, 0)); end
    n_tests++; if (frame_bits(129, 0) !== {24'h000002, 8'h00, 24'hFFFFFD, 8'h00}) begin n_fail++;
      $display("FAIL pat_frame2: got %h", frame_bits(129, 0)); end
    n_tests++; if (underrun_cnt !== 16'd0 || n_und != 0 || fifo_level !== 3'd1) begin n_fail++;
      $display("FAIL pat_side: cnt=%0d pulses=%0d level=%0d required 0 0 1", underrun_cnt, n_und, fifo_level); end
    enable = 1'b0;
    test_mode = 1'b0;
    repeat (4) @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_reset_mid();
`ifdef I2S_TX_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
